// File: rtl/scan_ctrl_pkg.sv
// Shared definitions for the sonar scan controller: FSM state encoding,
// angle code constants and the sweep configuration record.
package scan_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MOVE    = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_MEASURE = 3'd3,
    ST_REPORT  = 3'd4
  } scan_state_e;

  // 8'h00..8'hFF spans -90..+90 degrees
  localparam logic [7:0] ANGLE_MIN = 8'h00;
  localparam logic [7:0] ANGLE_MID = 8'h80;
  localparam logic [7:0] ANGLE_MAX = 8'hFF;

  typedef struct packed {
    logic [7:0] start_angle;
    logic [7:0] end_angle;
  } sweep_cfg_t;

  // A sweep needs a strictly increasing range; anything else is ignored.
  function automatic logic cfg_is_valid(input sweep_cfg_t cfg);
    return cfg.start_angle < cfg.end_angle;
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Clearable up-counter with a terminal-count flag; saturates at TERM so it
// never wraps. Used for both settle-pulse counting and the echo timeout.
module scan_timer #(
  parameter int W    = 8,
  parameter int TERM = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tc = (cnt_q == W'(TERM));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !tc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/scan_ctrl.sv
// Sonar scan sequencer: gates servo stepping, waits for the servo to settle,
// fires one ping per angle step and hands (angle, distance) records out.
module scan_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int TIMEOUT_CLKS  = 1500000,
  parameter int DIST_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [7:0]        cfg_start,
  input  logic [7:0]        cfg_end,
  input  logic [7:0]        servo_angle,
  input  logic              servo_cycle_done,
  output logic              move_en,
  output logic [7:0]        start_angle,
  output logic [7:0]        end_angle,
  output logic              sonar_trig,
  input  logic              sonar_done,
  input  logic [DIST_W-1:0] sonar_dist,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [7:0]        res_angle,
  output logic [DIST_W-1:0] res_dist,
  output logic              res_timeout,
  output logic              busy
);

  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam int TIMER_W  = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [DIST_W-1:0] DIST_NOECHO = {DIST_W{1'b1}};

  scan_state_e       state_q, state_d;
  logic              move_en_q, move_en_d;
  logic              sonar_trig_q, sonar_trig_d;
  logic              res_valid_q, res_valid_d;
  logic [7:0]        res_angle_q, res_angle_d;
  logic [DIST_W-1:0] res_dist_q, res_dist_d;
  logic              res_timeout_q, res_timeout_d;
  logic              busy_q, busy_d;
  logic [7:0]        start_angle_q, start_angle_d;
  logic [7:0]        end_angle_q, end_angle_d;
  logic [7:0]        last_angle_q, last_angle_d;

  logic       settle_tc;
  logic       tmo_tc;
  logic       cfg_ok;
  logic       angle_moved;
  logic       handshake;
  sweep_cfg_t cfg_in;

  assign cfg_in      = '{start_angle: cfg_start, end_angle: cfg_end};
  assign cfg_ok      = cfg_is_valid(cfg_in);
  assign angle_moved = (servo_angle != last_angle_q);
  assign handshake   = (state_q == ST_REPORT) && res_valid_q && res_ready;

  // Settle counter tallies PWM cycles; timeout timer tallies clocks since the ping.
  scan_timer #(.W(SETTLE_W), .TERM(SETTLE_CYCLES - 1)) u_settle (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q != ST_SETTLE),
    .inc   ((state_q == ST_SETTLE) && servo_cycle_done),
    .tc    (settle_tc)
  );

  scan_timer #(.W(TIMER_W), .TERM(TIMEOUT_CLKS - 1)) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q != ST_MEASURE),
    .inc   (state_q == ST_MEASURE),
    .tc    (tmo_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (enable && cfg_ok) state_d = ST_MOVE;
      end
      ST_MOVE: begin
        if (!enable)          state_d = ST_IDLE;
        else if (angle_moved) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!enable)                            state_d = ST_IDLE;
        else if (servo_cycle_done && settle_tc) state_d = ST_MEASURE;
      end
      // A ping in flight always completes, regardless of enable.
      ST_MEASURE: begin
        if (sonar_done || tmo_tc) state_d = ST_REPORT;
      end
      ST_REPORT: begin
        if (handshake) state_d = enable ? ST_MOVE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every port comes from a flop.
  always_comb begin
    move_en_d     = (state_d == ST_MOVE);
    busy_d        = (state_d != ST_IDLE);
    res_valid_d   = (state_d == ST_REPORT);
    sonar_trig_d  = (state_q == ST_SETTLE) && (state_d == ST_MEASURE);
    res_angle_d   = res_angle_q;
    res_dist_d    = res_dist_q;
    res_timeout_d = res_timeout_q;
    start_angle_d = start_angle_q;
    end_angle_d   = end_angle_q;
    last_angle_d  = last_angle_q;

    if (state_q == ST_IDLE && state_d == ST_MOVE) begin
      start_angle_d = cfg_start;
      end_angle_d   = cfg_end;
      last_angle_d  = servo_angle;
    end

    if (state_q == ST_MEASURE) begin
      if (sonar_done) begin
        res_angle_d   = servo_angle;
        res_dist_d    = sonar_dist;
        res_timeout_d = 1'b0;
      end else if (tmo_tc) begin
        res_angle_d   = servo_angle;
        res_dist_d    = DIST_NOECHO;
        res_timeout_d = 1'b1;
      end
    end

    if (handshake) begin
      last_angle_d = servo_angle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      move_en_q     <= 1'b0;
      sonar_trig_q  <= 1'b0;
      res_valid_q   <= 1'b0;
      res_angle_q   <= 8'h00;
      res_dist_q    <= '0;
      res_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
      start_angle_q <= ANGLE_MIN;
      end_angle_q   <= ANGLE_MAX;
      last_angle_q  <= 8'h00;
    end else begin
      move_en_q     <= move_en_d;
      sonar_trig_q  <= sonar_trig_d;
      res_valid_q   <= res_valid_d;
      res_angle_q   <= res_angle_d;
      res_dist_q    <= res_dist_d;
      res_timeout_q <= res_timeout_d;
      busy_q        <= busy_d;
      start_angle_q <= start_angle_d;
      end_angle_q   <= end_angle_d;
      last_angle_q  <= last_angle_d;
    end
  end

  assign move_en     = move_en_q;
  assign sonar_trig  = sonar_trig_q;
  assign res_valid   = res_valid_q;
  assign res_angle   = res_angle_q;
  assign res_dist    = res_dist_q;
  assign res_timeout = res_timeout_q;
  assign busy        = busy_q;
  assign start_angle = start_angle_q;
  assign end_angle   = end_angle_q;

endmodule

// File: tb/tb_scan_ctrl.sv
// Directed bench for scan_ctrl with a shortened echo timeout; servo and sonar
// are driven by hand from a single stimulus sequence.
module tb_scan_ctrl;

  localparam int SETTLE_CYCLES = 4;
  localparam int TIMEOUT_CLKS  = 40;
  localparam int DIST_W        = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic [7:0]        cfg_start;
  logic [7:0]        cfg_end;
  logic [7:0]        servo_angle;
  logic              servo_cycle_done;
  logic              move_en;
  logic [7:0]        start_angle;
  logic [7:0]        end_angle;
  logic              sonar_trig;
  logic              sonar_done;
  logic [DIST_W-1:0] sonar_dist;
  logic              res_valid;
  logic              res_ready;
  logic [7:0]        res_angle;
  logic [DIST_W-1:0] res_dist;
  logic              res_timeout;
  logic              busy;

  int errors  = 0;
  int checks  = 0;
  int trig_cnt = 0;

  scan_ctrl #(
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .TIMEOUT_CLKS  (TIMEOUT_CLKS),
    .DIST_W        (DIST_W)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .enable           (enable),
    .cfg_start        (cfg_start),
    .cfg_end          (cfg_end),
    .servo_angle      (servo_angle),
    .servo_cycle_done (servo_cycle_done),
    .move_en          (move_en),
    .start_angle      (start_angle),
    .end_angle        (end_angle),
    .sonar_trig       (sonar_trig),
    .sonar_done       (sonar_done),
    .sonar_dist       (sonar_dist),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_angle        (res_angle),
    .res_dist         (res_dist),
    .res_timeout      (res_timeout),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sonar_trig) trig_cnt <= trig_cnt + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_move_en"},     move_en,     0);
    chk({tag, "_trig"},        sonar_trig,  0);
    chk({tag, "_res_valid"},   res_valid,   0);
    chk({tag, "_res_angle"},   res_angle,   0);
    chk({tag, "_res_dist"},    res_dist,    0);
    chk({tag, "_res_timeout"}, res_timeout, 0);
    chk({tag, "_busy"},        busy,        0);
    chk({tag, "_start"},       start_angle, 32'h00);
    chk({tag, "_end"},         end_angle,   32'hFF);
  endtask

  task automatic cd_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      servo_cycle_done = 1'b1;
      step();
      servo_cycle_done = 1'b0;
      step();
    end
  endtask

  // Three gapped pulses, then the fourth; returns just after the trig edge.
  task automatic settle_to_trig(input string tag);
    cd_pulses(SETTLE_CYCLES - 1);
    servo_cycle_done = 1'b1;
    step();
    servo_cycle_done = 1'b0;
    chk({tag, "_trig"}, sonar_trig, 1);
  endtask

  initial begin
    int snap;
    int n;

    rst_n = 1'b0;
    enable = 1'b0;
    cfg_start = 8'h70;
    cfg_end = 8'h90;
    servo_angle = 8'h80;
    servo_cycle_done = 1'b0;
    sonar_done = 1'b0;
    sonar_dist = '0;
    res_ready = 1'b0;
    #12;
    check_reset("rst");
    #10;
    rst_n = 1'b1;
    step();

    // Invalid configuration is ignored
    cfg_start = 8'h90;
    cfg_end = 8'h70;
    enable = 1'b1;
    snap = trig_cnt;
    repeat (4) step();
    chk("badcfg_busy", busy, 0);
    chk("badcfg_move_en", move_en, 0);
    chk("badcfg_start", start_angle, 32'h00);
    chk("badcfg_trig", trig_cnt, snap);

    // Normal record
    cfg_start = 8'h70;
    cfg_end = 8'h90;
    step();
    chk("t1_move_en", move_en, 1);
    chk("t1_busy", busy, 1);
    chk("t1_start", start_angle, 32'h70);
    chk("t1_end", end_angle, 32'h90);
    cfg_start = 8'h00;
    cfg_end = 8'hFF;
    servo_angle = 8'h7F;
    step();
    chk("t1_move_drop", move_en, 0);
    snap = trig_cnt;
    cd_pulses(SETTLE_CYCLES - 1);
    chk("t1_no_early_trig", trig_cnt, snap);
    servo_cycle_done = 1'b1;
    step();
    servo_cycle_done = 1'b0;
    chk("t1_trig", sonar_trig, 1);
    step();
    chk("t1_trig_pulse", sonar_trig, 0);
    sonar_dist = 16'd300;
    sonar_done = 1'b1;
    step();
    sonar_done = 1'b0;
    chk("t1_valid", res_valid, 1);
    chk("t1_angle", res_angle, 32'h7F);
    chk("t1_dist", res_dist, 32'd300);
    chk("t1_timeout", res_timeout, 0);
    chk("t1_cfg_held", {start_angle, end_angle}, 32'h7090);

    // Backpressure: record held, servo frozen, no ping
    snap = trig_cnt;
    for (int i = 0; i < 50; i++) begin
      step();
      chk("t3_hold", {res_valid, move_en, res_angle, res_dist}, {6'd0, 1'b1, 1'b0, 8'h7F, 16'd300});
    end
    chk("t3_no_trig", trig_cnt, snap);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("t3_valid_drop", res_valid, 0);
    chk("t3_move_again", move_en, 1);

    // Echo timeout
    servo_angle = 8'h7E;
    step();
    chk("t2_settle", move_en, 0);
    settle_to_trig("t2");
    n = 0;
    while (!res_valid && n < 100) begin
      step();
      n++;
    end
    chk("t2_latency", n, TIMEOUT_CLKS);
    chk("t2_dist", res_dist, 32'hFFFF);
    chk("t2_timeout", res_timeout, 1);
    chk("t2_angle", res_angle, 32'h7E);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("t2_move_again", move_en, 1);

    // Stop during settle
    servo_angle = 8'h7D;
    step();
    cd_pulses(2);
    enable = 1'b0;
    step();
    chk("t5_idle_busy", busy, 0);
    chk("t5_idle_move", move_en, 0);
    snap = trig_cnt;
    cd_pulses(3);
    chk("t5_no_trig", trig_cnt, snap);
    chk("t5_still_idle", busy, 0);

    // Stop during measure; sonar_done coincides with the timeout edge
    cfg_start = 8'h10;
    cfg_end = 8'hF0;
    enable = 1'b1;
    step();
    chk("t5b_cfg", {start_angle, end_angle}, 32'h10F0);
    servo_angle = 8'h7C;
    step();
    settle_to_trig("t5b");
    enable = 1'b0;
    repeat (TIMEOUT_CLKS - 1) step();
    chk("t5b_not_yet", res_valid, 0);
    sonar_dist = 16'd500;
    sonar_done = 1'b1;
    step();
    sonar_done = 1'b0;
    chk("t5b_valid", res_valid, 1);
    chk("t5b_dist", res_dist, 32'd500);
    chk("t5b_done_wins", res_timeout, 0);
    chk("t5b_angle", res_angle, 32'h7C);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("t5b_idle", {busy, res_valid, move_en}, 0);

    // Reset while measuring; late echo ignored
    enable = 1'b1;
    step();
    servo_angle = 8'h7B;
    step();
    settle_to_trig("t6a");
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    check_reset("t6a");
    enable = 1'b0;
    sonar_dist = 16'd77;
    sonar_done = 1'b1;
    step();
    sonar_done = 1'b0;
    rst_n = 1'b1;
    step();
    sonar_done = 1'b1;
    step();
    sonar_done = 1'b0;
    chk("t6a_late_done", {busy, res_valid, res_dist}, 0);

    // Reset while reporting
    enable = 1'b1;
    step();
    servo_angle = 8'h7A;
    step();
    settle_to_trig("t6b");
    sonar_dist = 16'd123;
    sonar_done = 1'b1;
    step();
    sonar_done = 1'b0;
    chk("t6b_valid", res_valid, 1);
    chk("t6b_dist", res_dist, 32'd123);
    rst_n = 1'b0;
    #1;
    check_reset("t6b");
    enable = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("t6b_after", {busy, res_valid}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
